// File: rtl/mulnxn_bcd.sv
// Sequential NxN multiplier (nibble-serial) with shift-add-3 binary-to-BCD conversion
// and seven-segment decode with optional leading-zero blanking.
module mulnxn_bcd #(
    parameter int W     = 8,
    parameter int NDIG  = 5,
    parameter int BLANK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st,
    input  logic                sgn,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic                busy,
    output logic                done,
    output logic [2*W-1:0]      prod,
    output logic                neg,
    output logic                ovf,
    output logic [4*NDIG-1:0]   bcd,
    output logic [7*NDIG-1:0]   seg
);
    localparam int K   = W / 4;
    localparam int PW  = 2 * W;
    localparam int ND2 = (PW * 3) / 10 + 1;   // decimal digits of 2^PW-1 for PW in 16..64
    localparam int NB  = (ND2 > NDIG) ? ND2 : NDIG;
    localparam int CW  = $clog2(PW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    function automatic logic [4*NB-1:0] adj3(input logic [4*NB-1:0] v);
        adj3 = v;
        for (int i = 0; i < NB; i++)
            if (v[4*i +: 4] >= 4'd5) adj3[4*i +: 4] = v[4*i +: 4] + 4'd3;
    endfunction

    // Magnitude is taken in W unsigned bits, so the most negative value maps to 2^(W-1).
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
        mag = (s && x[W-1]) ? (~x + 1'b1) : x;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        ni_q, ni_d, nj_q, nj_d;
    logic [W-1:0]      ma_q, ma_d, mb_q, mb_d;
    logic              sneg_q, sneg_d;
    logic [PW-1:0]     acc_q, acc_d, bin_q, bin_d;
    logic [4*NB-1:0]   bw_q, bw_d, bw_adj, bw_nx;
    logic [PW-1:0]     prod_q, prod_d;
    logic              neg_q, neg_d, ovf_q, ovf_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic [7*NDIG-1:0] seg_q, seg_d, seg_n;
    logic              ovf_n, lead;
    logic [3:0]        na, nb;
    logic [7:0]        pp;
    logic [PW-1:0]     term;

    always_comb begin
        na   = 4'(ma_q >> (4 * ni_q));
        nb   = 4'(mb_q >> (4 * nj_q));
        pp   = na * nb;
        term = PW'(pp) << (4 * (ni_q + nj_q));
    end

    // Next conversion step plus the display view of it, used on the final CONV cycle.
    always_comb begin
        bw_adj = adj3(bw_q);
        bw_nx  = {bw_adj[4*NB-2:0], bin_q[PW-1]};
        ovf_n  = 1'b0;
        for (int i = NDIG; i < NB; i++)
            ovf_n = ovf_n | (bw_nx[4*i +: 4] != 4'd0);
        lead  = 1'b1;
        seg_n = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (bw_nx[4*i +: 4] != 4'd0) lead = 1'b0;
            if (!(lead && (i != 0) && (BLANK != 0) && !ovf_n))
                seg_n[7*i +: 7] = seg7(bw_nx[4*i +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ni_d    = ni_q;
        nj_d    = nj_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sneg_d  = sneg_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        bw_d    = bw_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        seg_d   = seg_q;
        case (state_q)
            S_IDLE: if (st) begin
                state_d = S_MUL;
                ma_d    = mag(a, sgn);
                mb_d    = mag(b, sgn);
                sneg_d  = sgn & (a[W-1] ^ b[W-1]);
                acc_d   = '0;
                ni_d    = '0;
                nj_d    = '0;
            end
            S_MUL: begin
                acc_d = acc_q + term;
                if (nj_q == 4'(K - 1)) begin
                    nj_d = '0;
                    ni_d = ni_q + 4'd1;
                    if (ni_q == 4'(K - 1)) begin
                        state_d = S_CONV;
                        bin_d   = acc_q + term;
                        bw_d    = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    nj_d = nj_q + 4'd1;
                end
            end
            S_CONV: begin
                bw_d  = bw_nx;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(PW - 1)) begin
                    state_d = S_OUT;
                    prod_d  = acc_q;
                    neg_d   = sneg_q && (acc_q != '0);
                    ovf_d   = ovf_n;
                    bcd_d   = bw_nx[4*NDIG-1:0];
                    seg_d   = seg_n;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            seg_q   <= seg_d;
        end
    end

    // Working registers are always initialised on entry to the phase that uses them.
    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        ni_q   <= ni_d;
        nj_q   <= nj_d;
        ma_q   <= ma_d;
        mb_q   <= mb_d;
        sneg_q <= sneg_d;
        acc_q  <= acc_d;
        bin_q  <= bin_d;
        bw_q   <= bw_d;
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_OUT);
    assign prod = prod_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
    assign bcd  = bcd_q;
    assign seg  = seg_q;
endmodule

// File: tb/tb_mulnxn_bcd.sv
// Scoreboard bench for mulnxn_bcd: W=8/NDIG=5, W=8/NDIG=4 (shared stimulus) and W=16/NDIG=10.
module tb_mulnxn_bcd;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic st = 1'b0, sgn = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic st2 = 1'b0, sgn2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;

    logic busy0, done0, neg0, ovf0;
    logic [15:0] prod0;
    logic [19:0] bcd0;
    logic [34:0] seg0;
    logic busy1, done1, neg1, ovf1;
    logic [15:0] prod1;
    logic [15:0] bcd1;
    logic [27:0] seg1;
    logic busy2, done2, neg2, ovf2;
    logic [31:0] prod2;
    logic [39:0] bcd2;
    logic [69:0] seg2;

    mulnxn_bcd #(.W(8), .NDIG(5), .BLANK(1)) dut0 (
        .clk(clk), .rst(rst), .st(st), .sgn(sgn), .a(a), .b(b),
        .busy(busy0), .done(done0), .prod(prod0), .neg(neg0), .ovf(ovf0), .bcd(bcd0), .seg(seg0));
    mulnxn_bcd #(.W(8), .NDIG(4), .BLANK(1)) dut1 (
        .clk(clk), .rst(rst), .st(st), .sgn(sgn), .a(a), .b(b),
        .busy(busy1), .done(done1), .prod(prod1), .neg(neg1), .ovf(ovf1), .bcd(bcd1), .seg(seg1));
    mulnxn_bcd #(.W(16), .NDIG(10), .BLANK(1)) dut2 (
        .clk(clk), .rst(rst), .st(st2), .sgn(sgn2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .prod(prod2), .neg(neg2), .ovf(ovf2), .bcd(bcd2), .seg(seg2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int LAT8  = 4 + 16 + 1;
    localparam int LAT16 = 16 + 32 + 1;

    typedef struct {
        logic [31:0] prod;
        logic        neg;
        logic        ovf;
        logic [39:0] bcd;
        logic [69:0] seg;
        int          due;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int total = 0, bad = 0;

    function automatic exp_t mk(input logic [31:0] p, input logic n, input logic o,
                                input logic [39:0] bc, input logic [69:0] sg);
        exp_t e;
        e.prod = p; e.neg = n; e.ovf = o; e.bcd = bc; e.seg = sg; e.due = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] p, input logic n,
                       input logic o, input logic [39:0] bc, input logic [69:0] sg);
        chk({tag, " done cycle"}, 70'(cyc), 70'(e.due));
        chk({tag, " prod"}, 70'(p), 70'(e.prod));
        chk({tag, " neg"}, 70'(n), 70'(e.neg));
        chk({tag, " ovf"}, 70'(o), 70'(e.ovf));
        chk({tag, " bcd"}, 70'(bc), 70'(e.bcd));
        chk({tag, " seg"}, sg, e.seg);
    endtask

    // Monitors: pop an expectation whenever a DUT signals done.
    always @(negedge clk) if (done0) begin
        if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL dut0 unexpected done got=1 want=0 (cyc %0d)", cyc);
        end else cmp("dut0", q0.pop_front(), 32'(prod0), neg0, ovf0, 40'(bcd0), 70'(seg0));
    end
    always @(negedge clk) if (done1) begin
        if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL dut1 unexpected done got=1 want=0 (cyc %0d)", cyc);
        end else cmp("dut1", q1.pop_front(), 32'(prod1), neg1, ovf1, 40'(bcd1), 70'(seg1));
    end
    always @(negedge clk) if (done2) begin
        if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL dut2 unexpected done got=1 want=0 (cyc %0d)", cyc);
        end else cmp("dut2", q2.pop_front(), prod2, neg2, ovf2, bcd2, seg2);
    end

    // Called at a falling edge; st is sampled on the next rising edge. rp>0 re-pulses st mid-op.
    task automatic issue(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                         input exp_t e0, input exp_t e1, input int rp);
        sgn = s; a = aa; b = bb; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        chk("busy after accept", 70'(busy0), 70'd1);
        e0.due = cyc + LAT8 - 1;
        e1.due = cyc + LAT8 - 1;
        q0.push_back(e0);
        q1.push_back(e1);
        for (int k = 1; k <= LAT8 + 2; k++) begin
            if (k == rp) begin st = 1'b1; a = 8'd9; end
            else st = 1'b0;
            @(negedge clk);
        end
        chk("hold prod", 70'(prod0), 70'(e0.prod));
        chk("idle busy", 70'(busy0), 70'd0);
    endtask

    task automatic issue16(input logic s, input logic [15:0] aa, input logic [15:0] bb, input exp_t e);
        sgn2 = s; a2 = aa; b2 = bb; st2 = 1'b1;
        @(negedge clk);
        st2 = 1'b0;
        e.due = cyc + LAT16 - 1;
        q2.push_back(e);
        repeat (LAT16 + 2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy", 70'(busy0), 70'd0);
        chk("reset done", 70'(done0), 70'd0);
        chk("reset prod", 70'(prod0), 70'd0);
        chk("reset bcd", 70'(bcd0), 70'd0);
        chk("reset seg", 70'(seg0), 70'd0);
        chk("reset busy w16", 70'(busy2), 70'd0);

        rst = 1'b1;
        issue(1'b0, 8'd255, 8'd255,
              mk(65025, 0, 0, 40'h65025, {7'h7D, 7'h6D, 7'h3F, 7'h5B, 7'h6D}),
              mk(65025, 0, 1, 40'h5025, {7'h6D, 7'h3F, 7'h5B, 7'h6D}), 0);
        issue(1'b0, 8'd0, 8'd200,
              mk(0, 0, 0, 40'h0, {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}),
              mk(0, 0, 0, 40'h0, {7'h00, 7'h00, 7'h00, 7'h3F}), 0);
        issue(1'b1, 8'hF6, 8'h0C,
              mk(120, 1, 0, 40'h120, {7'h00, 7'h00, 7'h06, 7'h5B, 7'h3F}),
              mk(120, 1, 0, 40'h120, {7'h00, 7'h06, 7'h5B, 7'h3F}), 0);
        issue(1'b1, 8'h80, 8'h80,
              mk(16384, 0, 0, 40'h16384, {7'h06, 7'h7D, 7'h4F, 7'h7F, 7'h66}),
              mk(16384, 0, 1, 40'h6384, {7'h7D, 7'h4F, 7'h7F, 7'h66}), 0);
        issue(1'b1, 8'h80, 8'h00,
              mk(0, 0, 0, 40'h0, {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}),
              mk(0, 0, 0, 40'h0, {7'h00, 7'h00, 7'h00, 7'h3F}), 0);
        issue(1'b1, 8'hFF, 8'hFF,
              mk(1, 0, 0, 40'h1, {7'h00, 7'h00, 7'h00, 7'h00, 7'h06}),
              mk(1, 0, 0, 40'h1, {7'h00, 7'h00, 7'h00, 7'h06}), 0);
        issue(1'b0, 8'd12, 8'd34,
              mk(408, 0, 0, 40'h408, {7'h00, 7'h00, 7'h66, 7'h3F, 7'h7F}),
              mk(408, 0, 0, 40'h408, {7'h00, 7'h66, 7'h3F, 7'h7F}), 0);
        issue(1'b1, 8'h7F, 8'h81,
              mk(16129, 1, 0, 40'h16129, {7'h06, 7'h7D, 7'h06, 7'h5B, 7'h6F}),
              mk(16129, 1, 1, 40'h6129, {7'h7D, 7'h06, 7'h5B, 7'h6F}), 0);
        issue(1'b0, 8'd100, 8'd100,
              mk(10000, 0, 0, 40'h10000, {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F}),
              mk(10000, 0, 1, 40'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}), 0);
        issue(1'b0, 8'd3, 8'd4,
              mk(12, 0, 0, 40'h12, {7'h00, 7'h00, 7'h00, 7'h06, 7'h5B}),
              mk(12, 0, 0, 40'h12, {7'h00, 7'h00, 7'h06, 7'h5B}), 5);

        // Abort: reset sampled 10 edges after the accepting edge; no done may follow.
        sgn = 1'b0; a = 8'd200; b = 8'd3; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 70'(busy0), 70'd0);
        chk("abort done", 70'(done0), 70'd0);
        chk("abort prod", 70'(prod0), 70'd0);
        chk("abort bcd", 70'(bcd0), 70'd0);
        chk("abort seg", 70'(seg0), 70'd0);
        chk("abort neg/ovf", 70'({neg0, ovf0}), 70'd0);
        rst = 1'b1;
        repeat (30) @(negedge clk);

        issue16(1'b0, 16'hFFFF, 16'hFFFF,
                mk(32'd4294836225, 0, 0, 40'h4294836225,
                   {7'h66, 7'h5B, 7'h6F, 7'h66, 7'h7F, 7'h4F, 7'h7D, 7'h5B, 7'h5B, 7'h6D}));
        issue16(1'b1, 16'h8000, 16'h8000,
                mk(32'd1073741824, 0, 0, 40'h1073741824,
                   {7'h06, 7'h3F, 7'h07, 7'h4F, 7'h07, 7'h66, 7'h06, 7'h7F, 7'h5B, 7'h66}));

        chk("dut0 pending", 70'(q0.size()), 70'd0);
        chk("dut1 pending", 70'(q1.size()), 70'd0);
        chk("dut2 pending", 70'(q2.size()), 70'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
